// File: rtl/shift_tx_pkg.sv
// Shared types and constants for the LSB-first serial transmitter.
// Optional parity frame bit is enabled by defining SHIFT_TX_PARITY_EN.
package shift_tx_pkg;

    // Transmitter states; PARITY is only reached when the parity bit is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } tx_state_t;

    // Word length matching the 4-bit serial-in/parallel-out receiver.
    localparam int unsigned SHIFT_TX_DEFAULT_WIDTH = 4;

    // Bits needed to count down from WIDTH-1 to 0; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : shift_tx_pkg

// File: rtl/shift_tx_bit_counter.sv
// Loadable down-counter tracking the remaining data bits of the current word.
// Loads WIDTH-1 on a new word and stops at zero; flags zero and one.
module shift_tx_bit_counter
    import shift_tx_pkg::*;
#(
    parameter  int unsigned WIDTH = SHIFT_TX_DEFAULT_WIDTH,
    localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o,
    output logic one_o
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_q;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= LOAD_VALUE;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Status flags consumed by the transmitter FSM.
    always_comb begin
        zero_o = (count_q == '0);
        one_o  = (count_q == CNT_W'(1));
    end

endmodule : shift_tx_bit_counter

// File: rtl/shift_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready
// handshake and sends it LSB first, one bit per clock, with frame and
// last_bit markers allowing gapless back-to-back words.
// Define SHIFT_TX_PARITY_EN to append an even-parity bit after each word.
module shift_transmitter
    import shift_tx_pkg::*;
#(
    parameter int unsigned WIDTH = SHIFT_TX_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             last_bit
);

`ifdef SHIFT_TX_PARITY_EN
    // With parity, the final data bit is not the last frame bit.
    localparam logic LAST_ON_DATA = 1'b0;
`else
    localparam logic LAST_ON_DATA = 1'b1;
`endif

    tx_state_t        state_q;
    logic [WIDTH-1:0] shift_q;
    logic             serial_q;
    logic             frame_q;
    logic             last_q;
`ifdef SHIFT_TX_PARITY_EN
    logic             parity_q;
`endif

    logic cnt_zero;
    logic cnt_one;
    logic load_fire;
    logic cnt_dec;

    // Ready in IDLE and in the final bit cycle so the next word follows without a gap.
    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            IDLE:   load_ready = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
            SHIFT:  load_ready = 1'b0;
            PARITY: load_ready = 1'b1;
`else
            SHIFT:  load_ready = cnt_zero;
`endif
            default: load_ready = 1'b0;
        endcase
    end

    // Handshake and counter controls.
    always_comb begin
        load_fire = load_valid && load_ready;
        cnt_dec   = (state_q == SHIFT) && !cnt_zero;
    end

    shift_tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clock  (clock),
        .reset  (reset),
        .load_i (load_fire),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero),
        .one_o  (cnt_one)
    );

    // FSM with registered serial outputs; a load on any ready cycle starts a new word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            serial_q <= 1'b0;
            frame_q  <= 1'b0;
            last_q   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load_fire) begin
            state_q  <= SHIFT;
            shift_q  <= data_in;
            serial_q <= data_in[0];
            frame_q  <= 1'b1;
            last_q   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity_q <= ^data_in;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (!cnt_zero) begin
                        // Next data bit; the bit shifted into position 0 goes out now.
                        shift_q  <= {1'b0, shift_q[WIDTH-1:1]};
                        serial_q <= shift_q[1];
                        frame_q  <= 1'b1;
                        last_q   <= LAST_ON_DATA & cnt_one;
                    end else begin
`ifdef SHIFT_TX_PARITY_EN
                        // Data done: one extra frame cycle carries the parity bit.
                        state_q  <= PARITY;
                        shift_q  <= '0;
                        serial_q <= parity_q;
                        frame_q  <= 1'b1;
                        last_q   <= 1'b1;
`else
                        state_q  <= IDLE;
                        shift_q  <= '0;
                        serial_q <= 1'b0;
                        frame_q  <= 1'b0;
                        last_q   <= 1'b0;
`endif
                    end
                end
`ifdef SHIFT_TX_PARITY_EN
                PARITY: begin
                    state_q  <= IDLE;
                    shift_q  <= '0;
                    serial_q <= 1'b0;
                    frame_q  <= 1'b0;
                    last_q   <= 1'b0;
                end
`endif
                default: begin
                    state_q  <= IDLE;
                    shift_q  <= '0;
                    serial_q <= 1'b0;
                    frame_q  <= 1'b0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

    // Port drivers.
    always_comb begin
        serial_out = serial_q;
        frame      = frame_q;
        last_bit   = last_q;
    end

endmodule : shift_transmitter

// File: tb/tb_shift_transmitter.sv
// Scoreboard bench for shift_transmitter: each accepted word pushes its
// expected frame bits into a queue; a negedge monitor pops and compares.
module tb_shift_transmitter;

    localparam int unsigned W = 4;
`ifdef SHIFT_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME_LEN = W + (PAR ? 1 : 0);

    logic         clock;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         serial_out;
    logic         frame;
    logic         last_bit;

    shift_transmitter #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .serial_out (serial_out),
        .frame      (frame),
        .last_bit   (last_bit)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int          errors = 0;
    int          checks = 0;
    logic [1:0]  exp_q[$];      // {serial bit, last_bit} per frame cycle
    int          busy_left = 0; // frame cycles still owed, including the one on the wire
    logic [3:0]  rx = 4'h0;     // negedge 4-bit receiver fed by the stream
    logic [1:0]  mon_e;
    logic        tb_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: frame must match whether the model owes a bit; then bit and last flag.
    always @(negedge clock) begin
        if (!reset) begin
            check("frame", {31'b0, frame}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
            if (frame) begin
                rx = {serial_out, rx[3:1]};
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("serial_out", {31'b0, serial_out}, {31'b0, mon_e[1]});
                    check("last_bit", {31'b0, last_bit}, {31'b0, mon_e[0]});
                end
            end else begin
                check("idle serial_out", {31'b0, serial_out}, 32'd0);
                check("idle last_bit", {31'b0, last_bit}, 32'd0);
            end
        end
    end

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input logic v, input logic [W-1:0] d, output logic acc);
        logic rdy;
        @(negedge clock);
        load_valid = v;
        data_in    = d;
        rdy        = (busy_left <= 1);
        #1;
        check("load_ready", {31'b0, load_ready}, {31'b0, rdy});
        @(posedge clock);
        acc = v && rdy;
        if (acc) begin
            for (int i = 0; i < int'(W); i++)
                exp_q.push_back({d[i], 1'(!PAR && (i == int'(W) - 1))});
            if (PAR)
                exp_q.push_back({^d, 1'b1});
            busy_left = FRAME_LEN;
        end else if (busy_left > 0) begin
            busy_left--;
        end
    endtask

    // Hold load_valid until accepted; data_in is junk until the model is ready.
    task automatic send(input logic [W-1:0] word);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 3 * FRAME_LEN && !acc; t++)
            step(1'b1, (busy_left <= 1) ? word : W'($urandom), acc);
        check("send accepted", {31'b0, acc}, 32'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++)
            step(1'b0, W'($urandom), acc);
    endtask

    initial begin
        reset      = 1'b1;
        load_valid = 1'b0;
        data_in    = '0;
        #1;
        check("reset load_ready", {31'b0, load_ready}, 32'd1);
        check("reset serial_out", {31'b0, serial_out}, 32'd0);
        check("reset frame", {31'b0, frame}, 32'd0);
        check("reset last_bit", {31'b0, last_bit}, 32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        idle(10);

        send(4'b1011);
        idle(4);
`ifndef SHIFT_TX_PARITY_EN
        check("receiver word", {28'b0, rx}, 32'hB);
`endif
        idle(2);

        // Back-to-back with load_valid held high.
        send(4'hA);
        send(4'h5);
        idle(FRAME_LEN + 2);

        // Reset in the middle of a word.
        send(4'hF);
        idle(2);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midword reset serial_out", {31'b0, serial_out}, 32'd0);
        check("midword reset frame", {31'b0, frame}, 32'd0);
        check("midword reset last_bit", {31'b0, last_bit}, 32'd0);
        check("midword reset load_ready", {31'b0, load_ready}, 32'd1);
        exp_q.delete();
        busy_left = 0;
        @(negedge clock);
        #2 reset = 1'b0;
        send(4'h3);
        idle(FRAME_LEN + 2);

        send(4'b0111);
        idle(FRAME_LEN + 2);

        // Random traffic with random valid and toggling data.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), W'($urandom), tb_acc);
        idle(FRAME_LEN + 2);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_transmitter

// File: doc/shift_transmitter.md
# shift_transmitter

Parallel-in, serial-out transmitter forming the sending end of the team's LSB-first serial link; its stream feeds the 4-bit serial-in/parallel-out receive register directly. It accepts a word over a valid/ready handshake, drives it out one bit per clock LSB first, and flags the final bit to allow gapless back-to-back words. Outputs change on the rising edge of clock, so a receiver sampling on the falling edge sees stable data.

## Interface
- WIDTH, 4, word length in bits (≥2); the default matches the 4-bit receiver.
- clock  input  1  transmit clock; all state updates on posedge.
- reset  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  word to transmit; sampled only on an accepted load.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word this cycle.
- serial_out  output  1  serial data, LSB first; 0 when idle.
- frame  output  1  high in every cycle where serial_out carries a data or parity bit.
- last_bit  output  1  high during the final bit cycle of the current word.

## Operation
- FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the configuration macro).
- Load accepted on posedge when load_valid && load_ready: shift register ← data_in, bit counter ← WIDTH-1, state → SHIFT.
- IDLE: load_ready=1, frame=0, serial_out=0, last_bit=0.
- SHIFT: serial_out = shift_reg[0], frame=1; each posedge shifts right (0 into MSB) and decrements the counter. last_bit=1 when counter==0, unless parity is enabled.
- End of SHIFT, counter==0: goes to PARITY if enabled. Otherwise goes to SHIFT with the new word if a load is accepted on that edge, or to IDLE if not.
- load_ready is combinational: 1 in IDLE, and 1 during the final bit cycle (SHIFT with counter==0 when parity is off, or PARITY). It is 0 in all other cycles.
- Word accepted during the final bit: its bit 0 appears in the very next cycle, and frame stays high with no gap.
- Counter width is $clog2(WIDTH); it never wraps below 0 because the state exits at 0.
- data_in changes while not loading are ignored. load_valid while load_ready=0 is held by the producer; no word is dropped.
- Reset mid-word: the word is abandoned and all outputs return to their reset values immediately (asynchronously).

## Timing
- Reset values: load_ready=1, serial_out=0, frame=0, last_bit=0, state=IDLE, shift register and counter all 0.
- Latency: a load accepted at edge N puts bit 0 on serial_out after edge N, and bit k after edge N+k.
- Word occupancy: WIDTH cycles of frame, or WIDTH+1 cycles with parity.
- Sustained throughput: one word every WIDTH (or WIDTH+1) cycles when load_valid is held high.
- For the 4-bit receiver: with four consecutive frame cycles, that receiver's register equals the transmitted word after its fourth falling edge.

## Configuration
- SHIFT_TX_PARITY_EN defined: after the last data bit, one PARITY cycle drives the even parity (XOR of all WIDTH data bits, latched at load) with frame=1 and last_bit=1.
- SHIFT_TX_PARITY_EN undefined: the PARITY state, parity register and logic are absent, and last_bit marks data bit WIDTH-1.

## Structure
- shift_tx_pkg holds:
  - the state enum typedef tx_state_t (IDLE, SHIFT, PARITY);
  - the localparam SHIFT_TX_DEFAULT_WIDTH = 4;
  - the function computing the counter width.
- One sub-module is natural: shift_tx_bit_counter, a loadable down-counter with a zero flag, parameterised by WIDTH. The FSM, shift register and parity stay in the top.

## Test plan
- Reset, then idle: load_ready=1, serial_out=0, frame=0 held for 10 cycles.
- Load 4'b1011 (WIDTH=4, no parity): serial_out over 4 cycles = 1,1,0,1, and frame is high exactly 4 cycles. last_bit is high only in cycle 4. The negedge 4-bit receiver then holds 4'b1011.
- load_valid held high with words 4'hA then 4'h5: the 8-bit stream is 0,1,0,1,1,0,1,0, frame is continuous with no gap cycle, and load_ready pulses only in the last bit cycle of each word.
- Assert reset after bit 2 of 4'hF: on assertion serial_out=0 and frame=0 with no further edge. After release load_ready=1 and the next load 4'h3 transmits 1,1,0,0.
- SHIFT_TX_PARITY_EN, WIDTH=4, load 4'b0111: the stream is 1,1,1,0 then parity 1, frame is high 5 cycles, and last_bit is high on the parity cycle only.
- load_valid asserted during bits 1–3 of a word with data_in toggling: that data is ignored, and the word presented at the final bit is the one loaded.
